// File: rtl/x_arbiter_if.sv
// x_arbiter_if: bundles the requester-side and downstream-side handshake
// signals of the x channel arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whoever drives requesters and downstream.
interface x_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int GRANT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      x_vld;
    logic [DATA_W-1:0]         x_data;
    logic                      x_rdy;
    logic [GRANT_W-1:0]        grant_id;
    logic                      err_overlen;

    modport slave (
        input  req_vld,
        input  req_data,
        input  req_last,
        output req_rdy,
        output x_vld,
        output x_data,
        input  x_rdy,
        output grant_id,
        output err_overlen
    );

    modport master (
        output req_vld,
        output req_data,
        output req_last,
        input  req_rdy,
        input  x_vld,
        input  x_data,
        output x_rdy,
        input  grant_id,
        input  err_overlen
    );
endinterface

// File: rtl/x_arbiter.sv
// x_arbiter: round-robin burst arbiter funnelling NUM_REQ requesters into a
// single registered valid/ready x channel. A grant is held for a whole burst
// (until last) or until MAX_BEATS beats, at which point it is forcibly
// released with a one-cycle err_overlen pulse. The interface instance must be
// built with the same NUM_REQ/DATA_W as this module.
module x_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    x_arbiter_if.slave bus
);
    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [GRANT_W-1:0]  grant_q;
    logic [GRANT_W-1:0]  rrPtr_q;
    logic [CNT_W-1:0]    beatCnt_q;
    logic                errOverlen_q;
    logic                xVld_q;
    logic                xVld_d;
    logic [DATA_W-1:0]   xData_q;
    logic [DATA_W-1:0]   xData_d;

    logic [DATA_W-1:0]   reqPayload [NUM_REQ];
    logic                pickValid;
    logic [GRANT_W-1:0]  pickIdx;
    logic                slotFree;
    logic                grantVld;
    logic                grantLast;
    logic                accept;
    logic [NUM_REQ-1:0]  reqRdy;

    // Split the flat payload bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqPayload[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first valid requester after rrPtr_q, wrapping; the
    // loop runs backwards so the nearest candidate is the one that sticks.
    always_comb begin
        logic [GRANT_W-1:0] cand;
        cand      = '0;
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GRANT_W'((int'(rrPtr_q) + k) % NUM_REQ);
            if (bus.req_vld[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign slotFree  = !xVld_q || bus.x_rdy;
    assign grantVld  = bus.req_vld[grant_q];
    assign grantLast = bus.req_last[grant_q];
    assign accept    = (state_q == BURST) && grantVld && slotFree;

    // Only the current grantee ever sees ready, and only while in BURST.
    always_comb begin
        reqRdy = '0;
        if (state_q == BURST) begin
            reqRdy[grant_q] = slotFree;
        end
    end

    // Next x beat: load on acceptance, otherwise drain or hold independently of the FSM.
    always_comb begin
        xVld_d  = xVld_q;
        xData_d = xData_q;
        if (accept) begin
            xVld_d  = 1'b1;
            xData_d = reqPayload[grant_q];
        end else if (xVld_q && bus.x_rdy) begin
            xVld_d = 1'b0;
        end
    end

    // x channel output register; reset discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xVld_q  <= 1'b0;
            xData_q <= '0;
        end else begin
            xVld_q  <= xVld_d;
            xData_q <= xData_d;
        end
    end

    // Arbitration FSM: grant in IDLE, count beats in BURST, release on last or overlength.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rrPtr_q      <= GRANT_W'(NUM_REQ - 1);
            beatCnt_q    <= '0;
            errOverlen_q <= 1'b0;
        end else begin
            errOverlen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        grant_q   <= pickIdx;
                        beatCnt_q <= '0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beatCnt_q <= beatCnt_q + CNT_W'(1);
                        if (grantLast) begin
                            state_q <= IDLE;
                            rrPtr_q <= grant_q;
                        end else if (beatCnt_q + CNT_W'(1) == CNT_W'(MAX_BEATS)) begin
                            state_q      <= IDLE;
                            rrPtr_q      <= grant_q;
                            errOverlen_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_rdy     = reqRdy;
    assign bus.x_vld       = xVld_q;
    assign bus.x_data      = xData_q;
    assign bus.grant_id    = grant_q;
    assign bus.err_overlen = errOverlen_q;
endmodule

// File: tb/tb_x_arbiter.sv
// tb_x_arbiter: directed checks of x_arbiter covering reset, single burst,
// round-robin fairness, backpressure, grantee gaps, overlength release and
// reset in the middle of a burst. Requester i always presents {i, d[23:0]}.
module tb_x_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passCount  = 0;
    int   checkCount = 0;

    x_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    x_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] payload(input int req, input logic [31:0] d);
        return {8'(req), d[23:0]};
    endfunction

    task automatic applyStimulus(input logic [3:0] vld, input logic [3:0] last,
                                 input logic xRdy, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.req_vld  = vld;
        bus.req_last = last;
        bus.x_rdy    = xRdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*DATA_W +: DATA_W] = payload(i, d);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        bus.req_vld  = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.x_rdy    = 1'b1;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst.x_vld",   32'(bus.x_vld), 0);
        checkOutput("rst.x_data",  bus.x_data, 0);
        checkOutput("rst.grant",   32'(bus.grant_id), 0);
        checkOutput("rst.req_rdy", 32'(bus.req_rdy), 0);
        checkOutput("rst.err",     32'(bus.err_overlen), 0);
        rst_n = 1'b1;

        $display("[TB] fairness");
        for (int c = 0; c < 12; c++) begin
            applyStimulus(4'hF, 4'hF, 1'b1, 32'h40 + c);
            if (c % 2 == 1) begin
                checkOutput("fair.grant",   32'(bus.grant_id), ((c - 1) / 2) % 4);
                checkOutput("fair.req_rdy", 32'(bus.req_rdy), 32'(1) << (((c - 1) / 2) % 4));
            end else begin
                checkOutput("fair.idle_rdy", 32'(bus.req_rdy), 0);
                if (c >= 2) begin
                    checkOutput("fair.x_vld",  32'(bus.x_vld), 1);
                    checkOutput("fair.x_data", bus.x_data,
                                payload(((c - 2) / 2) % 4, 32'h40 + c - 1));
                end
            end
        end
        applyStimulus(4'h0, 4'h0, 1'b1, 32'h0);

        $display("[TB] single burst");
        applyStimulus(4'b0100, 4'b0000, 1'b1, 32'hA);
        checkOutput("single.t_rdy", 32'(bus.req_rdy), 0);
        checkOutput("single.t_vld", 32'(bus.x_vld), 0);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 32'hA);
        checkOutput("single.t1_rdy",   32'(bus.req_rdy), 32'b0100);
        checkOutput("single.t1_grant", 32'(bus.grant_id), 2);
        checkOutput("single.t1_vld",   32'(bus.x_vld), 0);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 32'hB);
        checkOutput("single.t2_vld",  32'(bus.x_vld), 1);
        checkOutput("single.t2_data", bus.x_data, 32'h0200000A);
        checkOutput("single.t2_rdy",  32'(bus.req_rdy), 32'b0100);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 32'hC);
        checkOutput("single.t3_data", bus.x_data, 32'h0200000B);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("single.t4_data",  bus.x_data, 32'h0200000C);
        checkOutput("single.t4_vld",   32'(bus.x_vld), 1);
        checkOutput("single.t4_rdy",   32'(bus.req_rdy), 0);
        checkOutput("single.t4_grant", 32'(bus.grant_id), 2);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("single.t5_vld", 32'(bus.x_vld), 0);

        $display("[TB] backpressure");
        applyStimulus(4'b1000, 4'b0000, 1'b1, 32'h10);
        checkOutput("bp.idle_rdy", 32'(bus.req_rdy), 0);
        applyStimulus(4'b1000, 4'b0000, 1'b1, 32'h10);
        checkOutput("bp.grant", 32'(bus.grant_id), 3);
        checkOutput("bp.rdy1",  32'(bus.req_rdy), 32'b1000);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(4'b1000, 4'b0000, 1'b0, 32'h11);
            checkOutput("bp.stall_data", bus.x_data, 32'h03000010);
            checkOutput("bp.stall_vld",  32'(bus.x_vld), 1);
            checkOutput("bp.stall_rdy",  32'(bus.req_rdy), 0);
        end
        applyStimulus(4'b1000, 4'b0000, 1'b1, 32'h11);
        checkOutput("bp.resume_rdy",  32'(bus.req_rdy), 32'b1000);
        checkOutput("bp.resume_data", bus.x_data, 32'h03000010);
        applyStimulus(4'b1000, 4'b0000, 1'b1, 32'h12);
        checkOutput("bp.beat2", bus.x_data, 32'h03000011);
        applyStimulus(4'b1000, 4'b1000, 1'b1, 32'h13);
        checkOutput("bp.beat3", bus.x_data, 32'h03000012);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("bp.beat4", bus.x_data, 32'h03000013);
        checkOutput("bp.rdy_end", 32'(bus.req_rdy), 0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("bp.drained", 32'(bus.x_vld), 0);

        $display("[TB] grantee gap");
        applyStimulus(4'b0010, 4'b0000, 1'b1, 32'h20);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 32'h20);
        checkOutput("gap.grant", 32'(bus.grant_id), 1);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(4'b0101, 4'b0000, 1'b1, 32'h0);
            checkOutput("gap.hold_grant", 32'(bus.grant_id), 1);
            checkOutput("gap.hold_rdy",   32'(bus.req_rdy), 32'b0010);
            if (g == 0) begin
                checkOutput("gap.first_data", bus.x_data, 32'h01000020);
            end else begin
                checkOutput("gap.no_beat", 32'(bus.x_vld), 0);
            end
        end
        applyStimulus(4'b0010, 4'b0010, 1'b1, 32'h21);
        checkOutput("gap.resume_rdy", 32'(bus.req_rdy), 32'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("gap.last_data", bus.x_data, 32'h01000021);
        checkOutput("gap.end_rdy",   32'(bus.req_rdy), 0);

        $display("[TB] overlength");
        applyStimulus(4'b0010, 4'b0000, 1'b1, 32'h101);
        checkOutput("ovl.idle_rdy", 32'(bus.req_rdy), 0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(4'b1010, 4'b1000, 1'b1, 32'h100 + k);
            checkOutput("ovl.grant", 32'(bus.grant_id), 1);
            checkOutput("ovl.rdy",   32'(bus.req_rdy), 32'b0010);
            checkOutput("ovl.err_low", 32'(bus.err_overlen), 0);
            if (k >= 2) begin
                checkOutput("ovl.data", bus.x_data, payload(1, 32'h100 + k - 1));
            end
        end
        applyStimulus(4'b1010, 4'b1000, 1'b1, 32'h111);
        checkOutput("ovl.err_pulse", 32'(bus.err_overlen), 1);
        checkOutput("ovl.beat16",    bus.x_data, 32'h01000110);
        checkOutput("ovl.rel_rdy",   32'(bus.req_rdy), 0);
        applyStimulus(4'b1010, 4'b1000, 1'b1, 32'h111);
        checkOutput("ovl.err_once",  32'(bus.err_overlen), 0);
        checkOutput("ovl.next_grant", 32'(bus.grant_id), 3);
        checkOutput("ovl.next_rdy",  32'(bus.req_rdy), 32'b1000);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 32'h111);
        checkOutput("ovl.req3_data", bus.x_data, 32'h03000111);
        for (int k = 17; k <= 20; k++) begin
            applyStimulus(4'b0010, (k == 20) ? 4'b0010 : 4'b0000, 1'b1, 32'h100 + k - 6);
            checkOutput("ovl.tail_grant", 32'(bus.grant_id), 1);
            checkOutput("ovl.tail_rdy",   32'(bus.req_rdy), 32'b0010);
            if (k >= 18) begin
                checkOutput("ovl.tail_data", bus.x_data, payload(1, 32'h100 + k - 7));
            end
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h0);
        checkOutput("ovl.beat20", bus.x_data, 32'h0100010E);
        checkOutput("ovl.no_err", 32'(bus.err_overlen), 0);

        $display("[TB] reset mid-burst");
        applyStimulus(4'b0001, 4'b0000, 1'b1, 32'h30);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 32'h30);
        checkOutput("rmb.grant", 32'(bus.grant_id), 0);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 32'h31);
        checkOutput("rmb.pre_vld", 32'(bus.x_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rmb.x_vld",   32'(bus.x_vld), 0);
        checkOutput("rmb.x_data",  bus.x_data, 0);
        checkOutput("rmb.grant0",  32'(bus.grant_id), 0);
        checkOutput("rmb.req_rdy", 32'(bus.req_rdy), 0);
        checkOutput("rmb.err",     32'(bus.err_overlen), 0);
        bus.req_vld = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 4'b0000, 1'b1, 32'h50);
        checkOutput("rmb.idle_rdy", 32'(bus.req_rdy), 0);
        applyStimulus(4'b1001, 4'b0000, 1'b1, 32'h50);
        checkOutput("rmb.win_grant", 32'(bus.grant_id), 0);
        checkOutput("rmb.win_rdy",   32'(bus.req_rdy), 32'b0001);
        applyStimulus(4'b1001, 4'b0001, 1'b1, 32'h51);
        checkOutput("rmb.new_data", bus.x_data, 32'h00000050);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
